fir_tap_mac_8: RTL and testbench

// - Consumer of the 8-tap delay-line output: computes y = sum_{k=0..7} tap[k]*coef[k], signed.
// - Uses one time-shared multiplier-accumulator: 8 MAC cycles per sample, valid/ready on both sides.
// - Sits between the tap shift register (taps_flat) and the FIR output stage.
// - Intended for clk >> sample rate.

---
 rtl/fir_tap_mac_8_pkg.sv | 13 +
 rtl/fir_tap_mac_8_if.sv | 28 ++
 rtl/fir_tap_mac_8_mac_unit.sv | 38 +++
 rtl/fir_tap_mac_8.sv | 88 ++++++++
 tb/tb_fir_tap_mac_8.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_tap_mac_8_pkg.sv
// Shared constants and state encoding for the time-shared 8-tap FIR MAC.
package fir_pkg;

  localparam int unsigned NUM_TAPS   = 8;
  localparam int unsigned GUARD_BITS = $clog2(NUM_TAPS);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMac  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/fir_tap_mac_8_if.sv
// Sample-in / result-out valid-ready channels of the FIR tap MAC.
interface fir_tap_mac_8_if
  import fir_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned COEF_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = WIDTH + COEF_WIDTH + GUARD_BITS
);

  logic                           in_valid;
  logic                           in_ready;
  logic [WIDTH*NUM_TAPS-1:0]      taps_flat;
  logic [COEF_WIDTH*NUM_TAPS-1:0] coef_flat;
  logic                           out_valid;
  logic                           out_ready;
  logic [ACC_WIDTH-1:0]           out_data;

  modport master (
    output in_valid, taps_flat, coef_flat, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, taps_flat, coef_flat, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/fir_tap_mac_8_mac_unit.sv
// Signed multiplier feeding a clearable accumulator; one term per enabled cycle.
module fir_mac_unit #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned COEF_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 35
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        en,
  input  logic signed [WIDTH-1:0]     a,
  input  logic signed [COEF_WIDTH-1:0] b,
  output logic signed [ACC_WIDTH-1:0] acc
);

  localparam int unsigned ProdWidth = WIDTH + COEF_WIDTH;

  logic signed [ProdWidth-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0] w_prod_ext;
  logic signed [ACC_WIDTH-1:0] r_acc;

  // Sized casts of signed operands sign-extend, giving a full-precision product.
  assign w_prod     = ProdWidth'(a) * ProdWidth'(b);
  assign w_prod_ext = ACC_WIDTH'(w_prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (clr) begin
      r_acc <= '0;
    end else if (en) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

  assign acc = r_acc;

endmodule

// File: rtl/fir_tap_mac_8.sv
// 8-tap FIR dot product using one shared MAC: capture, 8 MAC cycles, hold result.
module fir_tap_mac_8
  import fir_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned COEF_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = WIDTH + COEF_WIDTH + GUARD_BITS
) (
  input logic           clk,
  input logic           rst,
  fir_tap_mac_8_if.slave bus
);

  state_e                      r_state;
  logic [2:0]                  r_idx;
  logic signed [WIDTH-1:0]     r_taps  [NUM_TAPS];
  logic signed [COEF_WIDTH-1:0] r_coefs [NUM_TAPS];
  logic                        r_out_valid;
  logic [ACC_WIDTH-1:0]        r_out_data;

  logic                        w_in_ready;
  logic                        w_accept;
  logic signed [ACC_WIDTH-1:0] w_acc;

  assign w_in_ready = (r_state == StIdle) && !rst;
  assign w_accept   = w_in_ready && bus.in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        r_taps[k]  <= '0;
        r_coefs[k] <= '0;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.in_valid) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
              r_taps[k]  <= bus.taps_flat[WIDTH*k +: WIDTH];
              r_coefs[k] <= bus.coef_flat[COEF_WIDTH*k +: COEF_WIDTH];
            end
            r_idx   <= '0;
            r_state <= StMac;
          end
        end
        StMac: begin
          r_idx <= r_idx + 3'd1;
          if (r_idx == 3'(NUM_TAPS - 1)) begin
            r_out_valid <= 1'b1;
            r_state     <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            // Keep the result visible after the handshake; the accumulator is reused.
            r_out_data  <= w_acc;
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  fir_mac_unit #(
    .WIDTH      (WIDTH),
    .COEF_WIDTH (COEF_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (w_accept),
    .en  (r_state == StMac),
    .a   (r_taps[r_idx]),
    .b   (r_coefs[r_idx]),
    .acc (w_acc)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = (r_state == StDone) ? w_acc : r_out_data;

endmodule

// File: tb/tb_fir_tap_mac_8.sv
// Directed bench for fir_tap_mac_8: sums, extremes, backpressure, capture, mid-run reset.
module tb_fir_tap_mac_8;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  fir_tap_mac_8_if bus ();

  fir_tap_mac_8 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ramp_unit;
    for (int k = 0; k < 8; k++) begin
      bus.taps_flat[16*k +: 16] = 16'(k + 1);
      bus.coef_flat[16*k +: 16] = 16'd1;
    end
  endtask

  // Drives one accept and waits (bounded) for out_valid; returns cycles after the accept edge.
  task automatic do_sample(output int lat, output logic [34:0] data);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    data = bus.out_data;
  endtask

  task automatic handshake;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready);
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
    end
    n_cmp++;
    if (bus.out_data !== 35'd0) begin
      n_bad++; $display("FAIL reset_out_data got=%0d want=0", bus.out_data);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL idle_in_ready got=%b want=1", bus.in_ready);
    end
  endtask

  task automatic test_basic_sum;
    int lat;
    logic [34:0] data;
    bit early;
    set_ramp_unit();
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_bad++; $display("FAIL mac_in_ready got=%b want=0", bus.in_ready);
    end
    early = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick();
      if (bus.out_valid !== 1'b0) early = 1'b1;
    end
    n_cmp++;
    if (early) begin
      n_bad++; $display("FAIL basic_early_valid got=1 want=0 before 8 cycles");
    end
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin
      n_bad++; $display("FAIL basic_valid_at_8 got=%b want=1", bus.out_valid);
    end
    n_cmp++;
    if (bus.out_data !== 35'd36) begin
      n_bad++; $display("FAIL basic_sum got=%0d want=36", bus.out_data);
    end
    handshake();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_release out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    n_cmp++;
    if (bus.out_data !== 35'd36) begin
      n_bad++; $display("FAIL basic_hold got=%0d want=36", bus.out_data);
    end
    lat = 0;
    data = '0;
  endtask

  task automatic test_neg_extreme;
    int lat;
    logic [34:0] data;
    bus.taps_flat = '0;
    bus.coef_flat = '0;
    bus.taps_flat[15:0] = 16'h8000;
    bus.coef_flat[15:0] = 16'h8000;
    do_sample(lat, data);
    n_cmp++;
    if (lat != 8) begin
      n_bad++; $display("FAIL neg_latency got=%0d want=8", lat);
    end
    n_cmp++;
    if (data !== 35'd1073741824) begin
      n_bad++; $display("FAIL neg_extreme got=%0d want=1073741824", data);
    end
    handshake();
  endtask

  task automatic test_full_scale;
    int lat;
    logic [34:0] data;
    for (int k = 0; k < 8; k++) begin
      bus.taps_flat[16*k +: 16] = 16'h8000;
      bus.coef_flat[16*k +: 16] = 16'h8000;
    end
    do_sample(lat, data);
    n_cmp++;
    if (data !== 35'd8589934592) begin
      n_bad++; $display("FAIL full_scale got=%0d want=8589934592", data);
    end
    handshake();
  endtask

  task automatic test_mixed_signs;
    int lat;
    logic [34:0] data;
    logic signed [34:0] exp_v;
    logic signed [15:0] tv;
    for (int k = 0; k < 8; k++) begin
      tv = 16'(k + 1);
      if (k % 2 == 1) tv = -tv;
      bus.taps_flat[16*k +: 16] = tv;
      bus.coef_flat[16*k +: 16] = 16'd3;
    end
    exp_v = -35'sd12;  // (1-2+3-4+5-6+7-8)*3
    do_sample(lat, data);
    n_cmp++;
    if (data !== exp_v) begin
      n_bad++; $display("FAIL mixed_signs got=%0d want=%0d", $signed(data), exp_v);
    end
    handshake();
  endtask

  task automatic test_backpressure;
    int lat;
    logic [34:0] data;
    bit bad;
    set_ramp_unit();
    do_sample(lat, data);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.out_valid !== 1'b1 || bus.out_data !== 35'd36 || bus.in_ready !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_bad++;
      $display("FAIL bp_hold out_valid=%b out_data=%0d in_ready=%b want 1/36/0",
               bus.out_valid, bus.out_data, bus.in_ready);
    end
    handshake();
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_capture_ignore;
    int lat;
    bit extra;
    set_ramp_unit();
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    for (int k = 0; k < 8; k++) bus.taps_flat[16*k +: 16] = 16'd100;
    bus.in_valid = 1'b1;
    tick();
    tick();
    bus.in_valid = 1'b0;
    lat = 3;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    n_cmp++;
    if (lat != 8) begin
      n_bad++; $display("FAIL capture_latency got=%0d want=8", lat);
    end
    n_cmp++;
    if (bus.out_data !== 35'd36) begin
      n_bad++; $display("FAIL capture_sum got=%0d want=36", bus.out_data);
    end
    handshake();
    extra = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.out_valid !== 1'b0) extra = 1'b1;
    end
    n_cmp++;
    if (extra) begin
      n_bad++; $display("FAIL ignored_request got=processed want=not processed");
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    logic [34:0] data;
    set_ramp_unit();
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_outputs out_valid=%b in_ready=%b want 0/0", bus.out_valid, bus.in_ready);
    end
    tick();
    tick();
    rst = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 35'd0) begin
      n_bad++;
      $display("FAIL midrst_cleared out_valid=%b out_data=%0d want 0/0", bus.out_valid, bus.out_data);
    end
    tick();
    do_sample(lat, data);
    n_cmp++;
    if (lat != 8 || data !== 35'd36) begin
      n_bad++; $display("FAIL midrst_next lat=%0d data=%0d want 8/36", lat, data);
    end
    handshake();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.taps_flat = '0;
    bus.coef_flat = '0;
    #2;
    test_reset();
    test_basic_sum();
    test_neg_extreme();
    test_full_scale();
    test_mixed_signs();
    test_backpressure();
    test_capture_ignore();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
